// File: rtl/adsr_envelope_generator.sv
// ADSR envelope generator: gate-driven Attack/Decay/Sustain/Release sequencer
// stepping a 16-bit level accumulator at a prescaled tick rate. The upper byte
// of the accumulator is registered out to the amplitude modulator.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | no note; acc held at 0
// ATTACK  | acc rises by attack step per tick until it saturates at 0xFFFF
// DECAY   | acc falls by decay step per tick down to the sustain level
// SUSTAIN | acc tracks {sustain_level, 8'h00} every cycle
// RELEASE | acc falls by release step per tick down to 0, then IDLE
module adsr_envelope_generator #(
    parameter int PRESCALE = 256
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       gate,
    input  logic       retrigger,
    input  logic [7:0] attack_rate,
    input  logic [7:0] decay_rate,
    input  logic [7:0] sustain_level,
    input  logic [7:0] release_rate,
    output logic [7:0] envelope_value,
    output logic [2:0] env_state,
    output logic       active
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] PRESC_MAX = CW'(PRESCALE - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_DECAY   = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } state_t;

    state_t         state_q, state_d;
    logic [15:0]    acc_q, acc_d;
    logic [CW-1:0]  presc_q, presc_d;
    logic [7:0]     envelope_value_q, envelope_value_d;
    logic [2:0]     env_state_q, env_state_d;
    logic           active_q, active_d;

    logic           tick;
    logic [7:0]     rate;
    logic [8:0]     step;
    logic [16:0]    sum;
    logic [15:0]    diff;
    logic           go_attack;
    logic           go_release;

    // Free-running prescaler; tick marks the last cycle of each period.
    always_comb begin
        tick    = (presc_q == PRESC_MAX);
        presc_d = tick ? '0 : presc_q + CW'(1);
    end

    // Envelope sequencing: gate/retrigger transitions win over tick and hold acc.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;

        case (state_q)
            ST_ATTACK: rate = attack_rate;
            ST_DECAY:  rate = decay_rate;
            default:   rate = release_rate;
        endcase
        step = {1'b0, rate} + 9'd1;
        sum  = {1'b0, acc_q} + {8'd0, step};
        diff = acc_q - {7'd0, step};

        go_attack  = gate && (retrigger || state_q == ST_IDLE || state_q == ST_RELEASE);
        go_release = !gate && (state_q == ST_ATTACK || state_q == ST_DECAY ||
                               state_q == ST_SUSTAIN);

        if (go_attack) begin
            state_d = ST_ATTACK;
        end else if (go_release) begin
            state_d = ST_RELEASE;
        end else begin
            case (state_q)
                ST_IDLE: acc_d = '0;
                ST_ATTACK: begin
                    if (tick) begin
                        if (sum >= 17'h0FFFF) begin
                            acc_d   = 16'hFFFF;
                            state_d = ST_DECAY;
                        end else begin
                            acc_d = sum[15:0];
                        end
                    end
                end
                ST_DECAY: begin
                    if (tick) begin
                        // Equality with step lands exactly on 0, so it counts as done too.
                        if (acc_q <= {7'd0, step} || diff[15:8] <= sustain_level) begin
                            acc_d   = {sustain_level, 8'h00};
                            state_d = ST_SUSTAIN;
                        end else begin
                            acc_d = diff;
                        end
                    end
                end
                ST_SUSTAIN: acc_d = {sustain_level, 8'h00};
                ST_RELEASE: begin
                    if (tick) begin
                        if (acc_q <= {7'd0, step}) begin
                            acc_d   = '0;
                            state_d = ST_IDLE;
                        end else begin
                            acc_d = diff;
                        end
                    end
                end
                default: begin
                    acc_d   = '0;
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Output stage samples the current acc/state, giving one cycle of latency.
    always_comb begin
        envelope_value_d = acc_q[15:8];
        env_state_d      = state_q;
        active_d         = (state_q != ST_IDLE);
    end

    // State, accumulator, prescaler and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= ST_IDLE;
            acc_q            <= '0;
            presc_q          <= '0;
            envelope_value_q <= '0;
            env_state_q      <= '0;
            active_q         <= 1'b0;
        end else begin
            state_q          <= state_d;
            acc_q            <= acc_d;
            presc_q          <= presc_d;
            envelope_value_q <= envelope_value_d;
            env_state_q      <= env_state_d;
            active_q         <= active_d;
        end
    end

    assign envelope_value = envelope_value_q;
    assign env_state      = env_state_q;
    assign active         = active_q;

endmodule

// File: tb/tb_adsr_envelope_generator.sv
// Bench for adsr_envelope_generator: two instances (PRESCALE=1 and 4) share
// stimulus; a behavioural model queues expected pins, a monitor compares them.
module tb_adsr_envelope_generator;

    logic       clk = 1'b0;
    logic       rst, gate, retrigger;
    logic [7:0] attack_rate, decay_rate, sustain_level, release_rate;
    logic [7:0] env1, env4;
    logic [2:0] st1, st4;
    logic       act1, act4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    adsr_envelope_generator #(.PRESCALE(1)) dut1 (
        .clk(clk), .rst(rst), .gate(gate), .retrigger(retrigger),
        .attack_rate(attack_rate), .decay_rate(decay_rate),
        .sustain_level(sustain_level), .release_rate(release_rate),
        .envelope_value(env1), .env_state(st1), .active(act1)
    );

    adsr_envelope_generator #(.PRESCALE(4)) dut4 (
        .clk(clk), .rst(rst), .gate(gate), .retrigger(retrigger),
        .attack_rate(attack_rate), .decay_rate(decay_rate),
        .sustain_level(sustain_level), .release_rate(release_rate),
        .envelope_value(env4), .env_state(st4), .active(act4)
    );

    typedef struct packed {
        logic [7:0] env;
        logic [2:0] st;
        logic       act;
    } pins_t;

    typedef struct packed {
        pins_t p1;
        pins_t p4;
    } exp_t;

    exp_t sbq[$];

    // Reference model: phases as integers 0..4, level as a plain integer.
    localparam int IDLE = 0, ATTACK = 1, DECAY = 2, SUSTAIN = 3, RELEASE = 4;
    int presc[2] = '{1, 4};
    int m_st[2];
    int m_acc[2];
    int m_cnt[2];

    task automatic model_edge(input int i);
        bit tick;
        int step;
        int nxt;
        bit moved;
        if (rst) begin
            m_st[i] = IDLE; m_acc[i] = 0; m_cnt[i] = 0;
            return;
        end
        tick = (m_cnt[i] == presc[i] - 1);
        m_cnt[i] = (m_cnt[i] + 1) % presc[i];
        moved = 1'b1;
        if (gate && retrigger)                         nxt = ATTACK;
        else if (gate && (m_st[i] == IDLE || m_st[i] == RELEASE)) nxt = ATTACK;
        else if (!gate && m_st[i] >= ATTACK && m_st[i] <= SUSTAIN) nxt = RELEASE;
        else moved = 1'b0;
        if (moved) begin
            m_st[i] = nxt;
            return;
        end
        if (m_st[i] == SUSTAIN) begin
            m_acc[i] = sustain_level * 256;
        end else if (m_st[i] == IDLE) begin
            m_acc[i] = 0;
        end else if (tick) begin
            if (m_st[i] == ATTACK) begin
                step = attack_rate + 1;
                if (m_acc[i] + step >= 65535) begin
                    m_acc[i] = 65535; m_st[i] = DECAY;
                end else m_acc[i] += step;
            end else if (m_st[i] == DECAY) begin
                step = decay_rate + 1;
                if (m_acc[i] <= step || (m_acc[i] - step) / 256 <= sustain_level) begin
                    m_acc[i] = sustain_level * 256; m_st[i] = SUSTAIN;
                end else m_acc[i] -= step;
            end else begin
                step = release_rate + 1;
                if (m_acc[i] <= step) begin
                    m_acc[i] = 0; m_st[i] = IDLE;
                end else m_acc[i] -= step;
            end
        end
    endtask

    function automatic pins_t pins_now(input int i);
        pins_t p;
        if (rst) p = '0;
        else begin
            p.env = 8'(m_acc[i] / 256);
            p.st  = 3'(m_st[i]);
            p.act = (m_st[i] != IDLE);
        end
        return p;
    endfunction

    // One clock: queue the pins expected after the edge, advance the model.
    task automatic cyc();
        exp_t e;
        e.p1 = pins_now(0);
        e.p4 = pins_now(1);
        model_edge(0);
        model_edge(1);
        sbq.push_back(e);
        @(posedge clk);
        @(negedge clk);
        retrigger = 1'b0;
    endtask

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Monitor: the pins are valid every cycle; compare just after each edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                checks++;
                if ({env1, st1, act1} != e.p1) begin
                    errors++;
                    $display("FAIL sb_p1 t=%0t got env=%0h st=%0d act=%0b expected env=%0h st=%0d act=%0b",
                             $time, env1, st1, act1, e.p1.env, e.p1.st, e.p1.act);
                end
                checks++;
                if ({env4, st4, act4} != e.p4) begin
                    errors++;
                    $display("FAIL sb_p4 t=%0t got env=%0h st=%0d act=%0b expected env=%0h st=%0d act=%0b",
                             $time, env4, st4, act4, e.p4.env, e.p4.st, e.p4.act);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; gate = 1'b0; retrigger = 1'b0;
        attack_rate = 8'h00; decay_rate = 8'h00; sustain_level = 8'h00; release_rate = 8'h00;
        repeat (3) cyc();
        rst = 1'b0;
        repeat (2) cyc();
        chk("reset_env", env1, 0);
        chk("reset_state", st1, 0);
        chk("reset_active", act1, 0);

        // Full attack then decay to sustain (PRESCALE=1 instance).
        attack_rate = 8'hFF; decay_rate = 8'h0F; sustain_level = 8'h80; release_rate = 8'hFF;
        gate = 1'b1;
        cyc();
        repeat (256) cyc();
        chk("attack_255_env", env1, 8'hFF);
        chk("attack_255_state", st1, ATTACK);
        cyc();
        chk("attack_sat_state", st1, DECAY);
        repeat (2100) cyc();
        chk("sustain_state", st1, SUSTAIN);
        chk("sustain_env", env1, 8'h80);
        sustain_level = 8'h40;
        cyc();
        chk("sustain_follow_1", env1, 8'h80);
        cyc();
        chk("sustain_follow_2", env1, 8'h40);
        sustain_level = 8'h80;
        repeat (3) cyc();

        // Release to idle.
        gate = 1'b0;
        repeat (140) cyc();
        chk("release_idle_state", st1, IDLE);
        chk("release_idle_active", act1, 0);

        // Retrigger from sustain holds the level (legato).
        gate = 1'b1; decay_rate = 8'hFF;
        repeat (500) cyc();
        chk("pre_retrig_state", st1, SUSTAIN);
        retrigger = 1'b1;
        cyc();
        cyc();
        chk("retrig_state", st1, ATTACK);
        chk("retrig_env", env1, 8'h80);

        // Retrigger with gate low is ignored.
        gate = 1'b0;
        repeat (20) cyc();
        retrigger = 1'b1;
        cyc();
        cyc();
        chk("retrig_gate0_state", st1, RELEASE);
        repeat (300) cyc();

        // Reset mid-decay.
        gate = 1'b1; attack_rate = 8'hFF; decay_rate = 8'h00;
        repeat (400) cyc();
        chk("pre_reset_state", st1, DECAY);
        rst = 1'b1; gate = 1'b0;
        cyc();
        rst = 1'b0;
        chk("mid_reset_p1", {env1, st1, act1}, 0);
        chk("mid_reset_p4", {env4, st4, act4}, 0);
        repeat (10) cyc();
        chk("post_reset_idle", st1, IDLE);

        // Randomized phase.
        for (int seg = 0; seg < 40; seg++) begin
            int hold;
            gate = 1'($urandom_range(0, 1));
            hold = $urandom_range(1, 700);
            if ($urandom_range(0, 3) == 0) attack_rate = 8'($urandom);
            else attack_rate = 8'($urandom_range(64, 255));
            decay_rate    = 8'($urandom);
            sustain_level = 8'($urandom);
            release_rate  = 8'($urandom);
            for (int c = 0; c < hold; c++) begin
                retrigger = ($urandom_range(0, 60) == 0);
                if ($urandom_range(0, 80) == 0) sustain_level = 8'($urandom);
                if ($urandom_range(0, 80) == 0) attack_rate = 8'($urandom);
                if ($urandom_range(0, 80) == 0) release_rate = 8'($urandom);
                if ($urandom_range(0, 80) == 0) gate = ~gate;
                rst = ($urandom_range(0, 3000) == 0);
                cyc();
                rst = 1'b0;
            end
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sbq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
